ahbl_bus_n: RTL and testbench
=============================

Name: ahbl_bus_n

Overview:
- Parametrised AHB-Lite single-master address decoder and slave-response multiplexer, sitting between one AHB-Lite master and up to 16 slaves.
- Decodes a configurable page field of HADDR into one-hot slave selects.
- Registers the data-phase selection and muxes HREADY/HRESP/HRDATA back to the master.
- Includes a built-in default slave: issues the two-cycle AHB ERROR response for active transfers to unmapped pages, counts such errors and captures the last faulting address.

Parameters:
- NUM_SLAVES, 8, number of slave ports (legal 1..16; elaboration error otherwise).
- PAGE_LSB, 24, lowest HADDR bit of the page field.
- PAGE_W, 8, page field width; field = HADDR[PAGE_LSB+PAGE_W-1 : PAGE_LSB]. PAGE_LSB+PAGE_W must be ≤ 32.
- S_PAGES, 0, packed NUM_SLAVES*PAGE_W vector; slice i is slave i's page.
- SLAVE_ENABLE, all ones, NUM_SLAVES-bit mask; a cleared bit makes slave i unmapped.
- BAD_DATA, 32'hDEADBEEF, HRDATA value when no slave owns the data phase.
- ERRCNT_W, 8, width of the decode-error counter.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type; bit1 = active (NONSEQ/SEQ).
- HREADY  out  1  bus ready to master and all slaves.
- HRESP  out  1  bus response to master (1 = ERROR).
- HRDATA  out  32  read data to master.
- HSEL  out  NUM_SLAVES  one-hot slave selects (address phase).
- HREADY_S  in  NUM_SLAVES  per-slave HREADYOUT.
- HRESP_S  in  NUM_SLAVES  per-slave HRESP.
- HRDATA_S  in  32*NUM_SLAVES  per-slave read data; slice i is slave i.
- ERR_COUNT  out  ERRCNT_W  saturating count of decode errors.
- ERR_ADDR  out  32  HADDR of the most recent decode error.

Behaviour:
- Decode is combinational. match[i] = (page field == S_PAGES slice i) & SLAVE_ENABLE[i].
- HSEL = lowest-index set bit of match only, so overlapping pages resolve to the lowest index. HSEL is independent of HTRANS; slaves qualify with HTRANS.
- unmapped = no match bit set.
- Data-phase select DSEL (NUM_SLAVES bits, one-hot or zero): loaded with HSEL on every rising HCLK where HREADY=1, otherwise held. Reset value 0.
- Default-slave FSM, states IDLE, ERR1, ERR2; reset state IDLE.
  - IDLE: leave for ERR1 on a clock where HREADY=1 & unmapped & HTRANS[1]=1; otherwise stay.
  - ERR1: drive HREADY=0, HRESP=1. Always go to ERR2.
  - ERR2: drive HREADY=1, HRESP=1. Sample the address phase exactly as in IDLE: go to ERR1 if another active unmapped transfer is presented, else IDLE.
- Output mux:
  - FSM in ERR1/ERR2: the FSM drives HREADY/HRESP; HRDATA = BAD_DATA.
  - Else if DSEL[i] set: HREADY = HREADY_S[i], HRESP = HRESP_S[i], HRDATA = slice i of HRDATA_S.
  - Else (no owner, or unmapped IDLE/BUSY transfer): HREADY=1, HRESP=0, HRDATA=BAD_DATA, i.e. a zero-wait OKAY.
- Mapped-slave ERROR responses pass through unchanged. They do not touch ERR_COUNT.
- Decode error event: the clock on which the FSM enters ERR1.
  - ERR_COUNT increments by 1 and saturates at all-ones; it never wraps.
  - ERR_ADDR loads the HADDR present on that clock.
  - Reset values: ERR_COUNT 0, ERR_ADDR 0.
- Immediately after reset deassertion: HREADY=1, HRESP=0, HRDATA=BAD_DATA, HSEL follows HADDR.
- Reset asserted mid-transfer (wait state or ERR1/ERR2) asynchronously clears DSEL, the FSM, ERR_COUNT and ERR_ADDR. Outputs return to the reset values above within the same cycle.
- Slave wait states: while HREADY=0 the address phase is not sampled. DSEL and the FSM hold, so HADDR changes during a stall have no effect on DSEL.
- Latency: zero added cycles for mapped slaves. An unmapped active transfer costs exactly 2 data-phase cycles.

Test Plan:
- NUM_SLAVES=4, PAGE_LSB=24, pages 00/10/20/30. NONSEQ read to 0x2000_0004 with HRDATA_S slice2=0x1234_5678 and HREADY_S[2]=1 → HSEL=4'b0100 in the address phase; next cycle HRDATA=0x1234_5678, HREADY=1, HRESP=0.
- Slave 1 inserts 3 wait states (HREADY_S[1]=0) on 0x1000_0000 while the master presents 0x3000_0000 → HREADY=0 for 3 cycles and DSEL stays slave 1. Slave 3 is selected only after HREADY=1.
- NONSEQ to 0x5000_0000 (unmapped) → cycle 1: HREADY=0, HRESP=1; cycle 2: HREADY=1, HRESP=1; HRDATA=0xDEADBEEF; ERR_COUNT=1; ERR_ADDR=0x5000_0000.
- IDLE transfer (HTRANS=0) to 0x5000_0000 → zero-wait OKAY, ERR_COUNT unchanged. SLAVE_ENABLE=4'b1101 with NONSEQ to 0x1000_0000 → error response.
- ERRCNT_W=2: 5 back-to-back unmapped NONSEQ (new one presented in each ERR2) → ERR_COUNT sequence 1,2,3,3,3. ERR1/ERR2 alternate with no IDLE gap.
- Overlap: slaves 0 and 2 both page 0x00 → HSEL=4'b0001. Also assert HRESETn low during ERR1 → HREADY=1, HRESP=0, ERR_COUNT=0 immediately.

Source files
------------

// File: rtl/ahbl_bus_n.sv
// AHB-Lite single-master address decoder and response multiplexer with a
// built-in default slave that answers unmapped active transfers with ERROR.
module ahbl_bus_n #(
    parameter int                           NUM_SLAVES   = 8,
    parameter int                           PAGE_LSB     = 24,
    parameter int                           PAGE_W       = 8,
    parameter logic [NUM_SLAVES*PAGE_W-1:0] S_PAGES      = '0,
    parameter logic [NUM_SLAVES-1:0]        SLAVE_ENABLE = '1,
    parameter logic [31:0]                  BAD_DATA     = 32'hDEADBEEF,
    parameter int                           ERRCNT_W     = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [31:0]              HRDATA,
    output logic [NUM_SLAVES-1:0]    HSEL,
    input  logic [NUM_SLAVES-1:0]    HREADY_S,
    input  logic [NUM_SLAVES-1:0]    HRESP_S,
    input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
    output logic [ERRCNT_W-1:0]      ERR_COUNT,
    output logic [31:0]              ERR_ADDR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
            $error("ahbl_bus_n: NUM_SLAVES must be in 1..16");
        end
        if (PAGE_LSB + PAGE_W > 32) begin : g_bad_page_field
            $error("ahbl_bus_n: PAGE_LSB+PAGE_W must not exceed 32");
        end
    endgenerate

    logic [PAGE_W-1:0]     page;
    logic [NUM_SLAVES-1:0] match;
    logic                  unmapped;
    logic                  err_event;
    logic                  unused_htrans0;

    logic [1:0]            state_reg, state_next;
    logic [NUM_SLAVES-1:0] dsel_reg;
    logic [ERRCNT_W-1:0]   err_count_reg;
    logic [31:0]           err_addr_reg;

    assign page           = HADDR[PAGE_LSB +: PAGE_W];
    assign unused_htrans0 = HTRANS[0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign match[gi] = (page == S_PAGES[gi*PAGE_W +: PAGE_W]) & SLAVE_ENABLE[gi];
        end
    endgenerate

    assign unmapped = ~|match;

    // Lowest index wins so overlapping page assignments still give one-hot HSEL.
    always_comb begin
        logic found;
        found = 1'b0;
        HSEL  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (match[i] && !found) begin
                HSEL[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    // HREADY never depends on HADDR/HTRANS, so this cannot form a loop.
    assign err_event = HREADY & unmapped & HTRANS[1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = err_event ? ST_ERR1 : ST_IDLE;
            ST_ERR1: state_next = ST_ERR2;
            ST_ERR2: state_next = err_event ? ST_ERR1 : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= ST_IDLE;
            dsel_reg      <= '0;
            err_count_reg <= '0;
            err_addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (HREADY) begin
                dsel_reg <= HSEL;
            end
            if (err_event) begin
                err_addr_reg <= HADDR;
                if (err_count_reg != '1) begin
                    err_count_reg <= err_count_reg + ERRCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = BAD_DATA;
        if (state_reg == ST_ERR1) begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
        end else if (state_reg == ST_ERR2) begin
            HRESP  = 1'b1;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_reg[i]) begin
                    HREADY = HREADY_S[i];
                    HRESP  = HRESP_S[i];
                    HRDATA = HRDATA_S[i*32 +: 32];
                end
            end
        end
    end

    assign ERR_COUNT = err_count_reg;
    assign ERR_ADDR  = err_addr_reg;

endmodule

// File: tb/tb_ahbl_bus_n.sv
// Directed bench for ahbl_bus_n: instance a checks mapped transfers, wait states
// and a single decode error; instance b checks overlap, disabled slave,
// counter saturation and reset during ERR1.
module tb_ahbl_bus_n;

    logic         clk = 1'b0;
    logic         rst_a_n, rst_b_n;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [3:0]   hready_s, hresp_s;
    logic [127:0] hrdata_s;

    logic         hready_a, hresp_a, hready_b, hresp_b;
    logic [31:0]  hrdata_a, hrdata_b, err_addr_a, err_addr_b;
    logic [3:0]   hsel_a, hsel_b;
    logic [7:0]   err_count_a;
    logic [1:0]   err_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahbl_bus_n #(
        .NUM_SLAVES(4), .PAGE_LSB(24), .PAGE_W(8),
        .S_PAGES(32'h30_20_10_00), .SLAVE_ENABLE(4'b1111),
        .BAD_DATA(32'hDEADBEEF), .ERRCNT_W(8)
    ) dut_a (
        .HCLK(clk), .HRESETn(rst_a_n), .HADDR(haddr), .HTRANS(htrans),
        .HREADY(hready_a), .HRESP(hresp_a), .HRDATA(hrdata_a), .HSEL(hsel_a),
        .HREADY_S(hready_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
        .ERR_COUNT(err_count_a), .ERR_ADDR(err_addr_a)
    );

    // Slaves 0 and 2 share page 0x00; slave 1 is disabled.
    ahbl_bus_n #(
        .NUM_SLAVES(4), .PAGE_LSB(24), .PAGE_W(8),
        .S_PAGES(32'h30_00_10_00), .SLAVE_ENABLE(4'b1101),
        .BAD_DATA(32'hDEADBEEF), .ERRCNT_W(2)
    ) dut_b (
        .HCLK(clk), .HRESETn(rst_b_n), .HADDR(haddr), .HTRANS(htrans),
        .HREADY(hready_b), .HRESP(hresp_b), .HRDATA(hrdata_b), .HSEL(hsel_b),
        .HREADY_S(hready_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
        .ERR_COUNT(err_count_b), .ERR_ADDR(err_addr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_both();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        htrans  = 2'b00;
        haddr   = 32'h0;
        repeat (2) next_cycle();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        hready_s = 4'b1111;
        hresp_s  = 4'b0000;
        hrdata_s = {32'hC3C3C3C3, 32'h12345678, 32'hB1B1B1B1, 32'hA0A0A0A0};
        reset_both();
        #1;
        chk("rst_hready", 32'(hready_a), 32'd1);
        chk("rst_hresp", 32'(hresp_a), 32'd0);
        chk("rst_hrdata", hrdata_a, 32'hDEADBEEF);
        chk("rst_errcnt", 32'(err_count_a), 32'd0);
        chk("rst_erraddr", err_addr_a, 32'd0);

        // Mapped read to slave 2.
        next_cycle(); haddr = 32'h2000_0004; htrans = 2'b10; #1;
        chk("a_hsel_s2", 32'(hsel_a), 32'b0100);
        next_cycle(); haddr = 32'h0000_0000; htrans = 2'b00; #1;
        chk("a_hrdata_s2", hrdata_a, 32'h12345678);
        chk("a_hready_s2", 32'(hready_a), 32'd1);
        chk("a_hresp_s2", 32'(hresp_a), 32'd0);
        chk("a_hsel_idle", 32'(hsel_a), 32'b0001);

        // Slave 1 stalls 3 cycles while the next address targets slave 3.
        next_cycle(); haddr = 32'h1000_0000; htrans = 2'b10; #1;
        chk("a_hsel_s1", 32'(hsel_a), 32'b0010);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); haddr = 32'h3000_0000; hready_s = 4'b1101; #1;
            chk("a_stall_hready", 32'(hready_a), 32'd0);
            chk("a_stall_hsel", 32'(hsel_a), 32'b1000);
        end
        next_cycle(); hready_s = 4'b1111; #1;
        chk("a_s1_done", 32'(hready_a), 32'd1);
        chk("a_s1_data", hrdata_a, 32'hB1B1B1B1);
        next_cycle(); haddr = 32'h0; htrans = 2'b00; hready_s = 4'b0111; #1;
        chk("a_s3_owner", 32'(hready_a), 32'd0);
        chk("a_s3_data", hrdata_a, 32'hC3C3C3C3);
        next_cycle(); hready_s = 4'b1111; #1;
        chk("a_s3_done", 32'(hready_a), 32'd1);

        // Unmapped NONSEQ: two-cycle ERROR.
        next_cycle(); haddr = 32'h5000_0000; htrans = 2'b10; #1;
        chk("a_hsel_unmap", 32'(hsel_a), 32'b0000);
        next_cycle(); htrans = 2'b00; #1;
        chk("a_err1_hready", 32'(hready_a), 32'd0);
        chk("a_err1_hresp", 32'(hresp_a), 32'd1);
        chk("a_err1_hrdata", hrdata_a, 32'hDEADBEEF);
        chk("a_err_count", 32'(err_count_a), 32'd1);
        chk("a_err_addr", err_addr_a, 32'h5000_0000);
        next_cycle(); #1;
        chk("a_err2_hready", 32'(hready_a), 32'd1);
        chk("a_err2_hresp", 32'(hresp_a), 32'd1);
        chk("a_err2_hrdata", hrdata_a, 32'hDEADBEEF);

        // IDLE transfer to an unmapped page gives zero-wait OKAY.
        next_cycle(); #1;
        chk("a_idle_hready", 32'(hready_a), 32'd1);
        chk("a_idle_hresp", 32'(hresp_a), 32'd0);
        chk("a_idle_hrdata", hrdata_a, 32'hDEADBEEF);
        next_cycle(); #1;
        chk("a_idle_nocnt", 32'(err_count_a), 32'd1);
        chk("a_idle_hresp2", 32'(hresp_a), 32'd0);

        reset_both();
        #1;
        chk("b_overlap", 32'(hsel_b), 32'b0001);

        // Disabled slave 1 decodes as unmapped, then back-to-back errors.
        next_cycle(); haddr = 32'h1000_0000; htrans = 2'b10; #1;
        chk("b_hsel_dis", 32'(hsel_b), 32'b0000);
        for (int k = 0; k < 5; k++) begin
            next_cycle(); haddr = 32'h5000_0000; #1;
            chk("b_err1_hready", 32'(hready_b), 32'd0);
            chk("b_err1_hresp", 32'(hresp_b), 32'd1);
            chk("b_err_count", 32'(err_count_b), 32'(cnt_exp[k]));
            if (k == 0) chk("b_err_addr_dis", err_addr_b, 32'h1000_0000);
            next_cycle(); #1;
            chk("b_err2_hready", 32'(hready_b), 32'd1);
            chk("b_err2_hresp", 32'(hresp_b), 32'd1);
        end
        chk("b_err_addr", err_addr_b, 32'h5000_0000);

        // Reset asserted in the middle of ERR1.
        next_cycle(); htrans = 2'b00; haddr = 32'h0; #1;
        chk("b_pre_rst", 32'(hready_b), 32'd0);
        rst_b_n = 1'b0; #1;
        chk("b_rst_hready", 32'(hready_b), 32'd1);
        chk("b_rst_hresp", 32'(hresp_b), 32'd0);
        chk("b_rst_errcnt", 32'(err_count_b), 32'd0);
        chk("b_rst_erraddr", err_addr_b, 32'd0);
        chk("b_rst_hrdata", hrdata_b, 32'hDEADBEEF);
        #2; rst_b_n = 1'b1;
        next_cycle(); #1;
        chk("b_post_rst", 32'(hready_b), 32'd1);
        chk("b_post_hrdata", hrdata_b, 32'hA0A0A0A0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
